// File: rtl/line_fill_responder.sv
// Main-memory responder for cache line refills and writebacks: fixed read latency, one beat per cycle.
// Optional macro CRITICAL_WORD_FIRST_EN starts refills at the requested word and wraps within the line.
module line_fill_responder #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned LINE_WORDS  = 4,
    parameter int unsigned DEPTH_WORDS = 65536,
    parameter int unsigned LATENCY     = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [WIDTH-1:0] req_addr,
    input  logic             wdata_valid,
    output logic             wdata_ready,
    input  logic [WIDTH-1:0] wdata,
    output logic             rdata_valid,
    output logic [WIDTH-1:0] rdata,
    output logic             rdata_last,
    output logic             wr_done,
    output logic             busy
);

    localparam int unsigned AW    = $clog2(DEPTH_WORDS);
    localparam int unsigned BW    = $clog2(LINE_WORDS);
    localparam int unsigned LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [BW-1:0]    LAST_BEAT = BW'(LINE_WORDS - 1);
    localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'((LATENCY > 0) ? LATENCY - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_READ,
        S_WRITE
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [AW-BW-1:0] r_line;
    logic [BW-1:0]    r_start;
    logic [BW-1:0]    r_beat;
    logic [LAT_W-1:0] r_lat;
    logic [WIDTH-1:0] r_rdata;
    logic             r_wr_done;
    logic [WIDTH-1:0] r_mem [DEPTH_WORDS];

    logic [AW-1:0]    w_req_word;
    logic [AW-BW-1:0] w_req_line;
    logic [BW-1:0]    w_req_start;
    logic             w_unused_addr;
    logic [AW-BW-1:0] w_rd_line;
    logic [BW-1:0]    w_rd_offset;
    logic             w_rd_load;
    logic             w_wr_beat;

    assign w_req_word = req_addr[AW+1:2];
    assign w_req_line = w_req_word[AW-1:BW];

`ifdef CRITICAL_WORD_FIRST_EN
    assign w_req_start   = req_write ? '0 : w_req_word[BW-1:0];
    assign w_unused_addr = ^{req_addr[WIDTH-1:AW+2], req_addr[1:0]};
`else
    assign w_req_start   = '0;
    assign w_unused_addr = ^{req_addr[WIDTH-1:AW+2], req_addr[1:0], w_req_word[BW-1:0]};
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_write) begin
                        w_state_next = S_WRITE;
                    end else if (LATENCY > 0) begin
                        w_state_next = S_WAIT;
                    end else begin
                        w_state_next = S_READ;
                    end
                end
            end
            S_WAIT: begin
                if (r_lat == LAT_LAST) begin
                    w_state_next = S_READ;
                end
            end
            S_READ: begin
                if (r_beat == LAST_BEAT) begin
                    w_state_next = S_IDLE;
                end
            end
            S_WRITE: begin
                if (wdata_valid && (r_beat == LAST_BEAT)) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Refill data is fetched one edge ahead: beat 0 on the edge entering READ,
    // beat k+1 while beat k is on the bus. With zero latency the address comes straight from the request.
    always_comb begin
        w_rd_line   = r_line;
        w_rd_offset = r_start;
        if (r_state == S_IDLE) begin
            w_rd_line   = w_req_line;
            w_rd_offset = w_req_start;
        end else if (r_state == S_READ) begin
            w_rd_offset = r_start + r_beat + 1'b1;
        end
    end

    assign w_rd_load = (w_state_next == S_READ);
    assign w_wr_beat = (r_state == S_WRITE) && wdata_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_line    <= '0;
            r_start   <= '0;
            r_beat    <= '0;
            r_lat     <= '0;
            r_rdata   <= '0;
            r_wr_done <= 1'b0;
        end else begin
            r_wr_done <= 1'b0;
            if (w_rd_load) begin
                r_rdata <= r_mem[{w_rd_line, w_rd_offset}];
            end
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_line  <= w_req_line;
                        r_start <= w_req_start;
                        r_beat  <= '0;
                        r_lat   <= '0;
                    end
                end
                S_WAIT:  r_lat  <= r_lat + 1'b1;
                S_READ:  r_beat <= r_beat + 1'b1;
                S_WRITE: begin
                    if (wdata_valid) begin
                        r_beat <= r_beat + 1'b1;
                        if (r_beat == LAST_BEAT) begin
                            r_wr_done <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Backing store is deliberately not reset; reset forces IDLE, which blocks further writes.
    always_ff @(posedge clk) begin
        if (w_wr_beat) begin
            r_mem[{r_line, r_beat}] <= wdata;
        end
    end

    assign req_ready   = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign wdata_ready = (r_state == S_WRITE);
    assign rdata_valid = (r_state == S_READ);
    assign rdata_last  = (r_state == S_READ) && (r_beat == LAST_BEAT);
    assign rdata       = r_rdata;
    assign wr_done     = r_wr_done;

endmodule
